// File: rtl/iic_sample_fifo_pkg.sv
// Shared audio-path definitions for the sample FIFO and the delta-sigma modulator:
// default sample width, mid-scale silence word and oversampling-ratio encodings.
package iic_sample_fifo_pkg;

   localparam int unsigned BW_DEFAULT         = 16;
   localparam int unsigned DEPTH_LOG2_DEFAULT = 4;
   localparam int unsigned AE_THRESH_DEFAULT  = 4;
   localparam int unsigned UNDERRUN_CNT_W     = 8;

   // Mid-scale UINT code: a leading one followed by zeros, i.e. zero signal level.
   localparam logic [BW_DEFAULT-1:0] DATA_MID_DEFAULT = {1'b1, {(BW_DEFAULT-1){1'b0}}};

   typedef enum logic [1:0] {
      OSR_64  = 2'd0,
      OSR_128 = 2'd1,
      OSR_256 = 2'd2,
      OSR_512 = 2'd3
   } osr_e;

endpackage : iic_sample_fifo_pkg

// File: rtl/iic_fifo_mem.sv
// Register-array storage for the sample FIFO: one synchronous write port and one
// asynchronous read port, so the owner can register the read word itself.
module iic_fifo_mem #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 4
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   // Storage words carry no reset; validity is tracked by the owner's level counter.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : iic_fifo_mem

// File: rtl/iic_sample_fifo.sv
// Sample buffer feeding the delta-sigma modulator: holds one registered output word,
// flags overflow/underrun. Optional saturating underrun counter: IIC_SAMPLE_FIFO_UNDERRUN_CNT_EN.
module iic_sample_fifo
   import iic_sample_fifo_pkg::*;
#(
   parameter int unsigned BW         = BW_DEFAULT,
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
   parameter int unsigned AE_THRESH  = AE_THRESH_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [BW-1:0]         wr_data_i,
   input  logic                  wr_en_i,
   output logic                  full_o,
   output logic                  overflow_o,
   input  logic                  rd_i,
   output logic [BW-1:0]         data_o,
   output logic                  empty_o,
   output logic                  almost_empty_o,
   output logic                  underrun_o,
   output logic [DEPTH_LOG2:0]   level_o,
   input  logic                  flush_i,
   input  logic                  clr_flags_i
`ifdef IIC_SAMPLE_FIFO_UNDERRUN_CNT_EN
   ,
   output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
`endif
);

   localparam logic [BW-1:0]         DATA_MID  = {1'b1, {(BW-1){1'b0}}};
   localparam logic [DEPTH_LOG2:0]   LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   LVL_ZERO  = {(DEPTH_LOG2+1){1'b0}};
   localparam logic [DEPTH_LOG2:0]   LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   LVL_AE    = (DEPTH_LOG2+1)'(AE_THRESH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = {DEPTH_LOG2{1'b0}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [BW-1:0]         data_q, data_d;
   logic                  ovf_q, ovf_d;
   logic                  und_q, und_d;

   logic [BW-1:0]         mem_rdata_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  rd_accept_s;
   logic                  wr_accept_s;
   logic                  ovf_event_s;
   logic                  und_event_s;

   assign full_s  = (level_q == LVL_FULL);
   assign empty_s = (level_q == LVL_ZERO);

   // A read frees a slot in the same cycle, so a write at full is still accepted alongside it.
   assign rd_accept_s = rd_i & ~empty_s & ~flush_i;
   assign wr_accept_s = wr_en_i & (~full_s | rd_accept_s) & ~flush_i;
   assign ovf_event_s = wr_en_i & full_s & ~rd_accept_s & ~flush_i;
   assign und_event_s = rd_i & empty_s & ~flush_i;

   iic_fifo_mem #(
      .DW (BW),
      .AW (DEPTH_LOG2)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (wr_accept_s),
      .waddr_i (wptr_q),
      .wdata_i (wr_data_i),
      .raddr_i (rptr_q),
      .rdata_o (mem_rdata_s)
   );

   // Next-state for pointers, level, output word and sticky flags.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      und_d   = und_q;
      if (flush_i) begin
         wptr_d  = PTR_ZERO;
         rptr_d  = PTR_ZERO;
         level_d = LVL_ZERO;
         data_d  = DATA_MID;
         ovf_d   = 1'b0;
         und_d   = 1'b0;
      end else begin
         if (wr_accept_s) begin
            wptr_d = wptr_q + PTR_ONE;
         end else begin
            wptr_d = wptr_q;
         end
         if (rd_accept_s) begin
            rptr_d = rptr_q + PTR_ONE;
            data_d = mem_rdata_s;
         end else if (rd_i) begin
            data_d = DATA_MID;
         end else begin
            data_d = data_q;
         end
         case ({wr_accept_s, rd_accept_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
         ovf_d = ovf_event_s | (ovf_q & ~clr_flags_i);
         und_d = und_event_s | (und_q & ~clr_flags_i);
      end
   end

   // State registers; reset discards all contents immediately.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr_q  <= PTR_ZERO;
         rptr_q  <= PTR_ZERO;
         level_q <= LVL_ZERO;
         data_q  <= DATA_MID;
         ovf_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         und_q   <= und_d;
      end
   end

`ifdef IIC_SAMPLE_FIFO_UNDERRUN_CNT_EN
   localparam logic [UNDERRUN_CNT_W-1:0] CNT_ZERO = {UNDERRUN_CNT_W{1'b0}};
   localparam logic [UNDERRUN_CNT_W-1:0] CNT_ONE  = {{(UNDERRUN_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX  = {UNDERRUN_CNT_W{1'b1}};

   logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

   // Saturating underrun count; a same-cycle event beats a flag clear.
   always_comb begin
      ucnt_d = ucnt_q;
      if (flush_i) begin
         ucnt_d = CNT_ZERO;
      end else if (und_event_s && clr_flags_i) begin
         ucnt_d = CNT_ONE;
      end else if (und_event_s) begin
         if (ucnt_q == CNT_MAX) begin
            ucnt_d = CNT_MAX;
         end else begin
            ucnt_d = ucnt_q + CNT_ONE;
         end
      end else if (clr_flags_i) begin
         ucnt_d = CNT_ZERO;
      end else begin
         ucnt_d = ucnt_q;
      end
   end

   // Underrun counter register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ucnt_q <= CNT_ZERO;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign underrun_cnt_o = ucnt_q;
`endif

   assign data_o         = data_q;
   assign level_o        = level_q;
   assign full_o         = full_s;
   assign empty_o        = empty_s;
   assign almost_empty_o = (level_q <= LVL_AE);
   assign overflow_o     = ovf_q;
   assign underrun_o     = und_q;

endmodule : iic_sample_fifo

// File: tb/tb_iic_sample_fifo.sv
// Self-checking bench for iic_sample_fifo against a queue-based reference model.
module tb_iic_sample_fifo;

   localparam int          DEPTH = 16;
   localparam int          AE    = 4;
   localparam logic [15:0] MID   = 16'h8000;

   logic        clk;
   logic        rst_n;
   logic [15:0] wr_data;
   logic        wr_en;
   logic        full;
   logic        overflow;
   logic        rd;
   logic [15:0] data;
   logic        empty;
   logic        almost_empty;
   logic        underrun;
   logic [4:0]  level;
   logic        flush;
   logic        clr_flags;
`ifdef IIC_SAMPLE_FIFO_UNDERRUN_CNT_EN
   logic [7:0]  ucnt;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] mq[$];
   logic [15:0] m_data;
   bit          m_ovf;
   bit          m_und;
   int          m_cnt;

   iic_sample_fifo dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .wr_data_i      (wr_data),
      .wr_en_i        (wr_en),
      .full_o         (full),
      .overflow_o     (overflow),
      .rd_i           (rd),
      .data_o         (data),
      .empty_o        (empty),
      .almost_empty_o (almost_empty),
      .underrun_o     (underrun),
      .level_o        (level),
      .flush_i        (flush),
      .clr_flags_i    (clr_flags)
`ifdef IIC_SAMPLE_FIFO_UNDERRUN_CNT_EN
      ,
      .underrun_cnt_o (ucnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      m_data = MID;
      m_ovf  = 1'b0;
      m_und  = 1'b0;
      m_cnt  = 0;
   endtask

   // Drive one cycle, advance the model at the edge, leave outputs settled 1 time unit later.
   task automatic step(input bit wr, input logic [15:0] wd, input bit r, input bit fl, input bit cl);
      bit was_full, was_empty, rd_ok, ov_ev, un_ev;
      wr_en = wr; wr_data = wd; rd = r; flush = fl; clr_flags = cl;
      @(posedge clk);
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (fl) begin
         model_reset();
      end else begin
         rd_ok = r && !was_empty;
         ov_ev = wr && was_full && !rd_ok;
         un_ev = r && was_empty;
         if (rd_ok) m_data = mq.pop_front();
         else if (r) m_data = MID;
         if (wr && !ov_ev) mq.push_back(wd);
         m_ovf = ov_ev || (m_ovf && !cl);
         m_und = un_ev || (m_und && !cl);
         if (un_ev && cl) m_cnt = 1;
         else if (un_ev) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         else if (cl) m_cnt = 0;
      end
      #1;
      wr_en = 1'b0; rd = 1'b0; flush = 1'b0; clr_flags = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      checks++; if (data !== 16'h8000) begin failures++; $display("FAIL reset_data got=%h exp=8000", data); end
      checks++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_status got e=%b ae=%b f=%b exp 1 1 0", empty, almost_empty, full); end
      checks++; if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (underrun !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_flags got u=%b o=%b exp 0 0", underrun, overflow); end
      #2 rst_n = 1'b1;
      #1;
   endtask

   task automatic test_basic();
      step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
      checks++; if (level !== 5'd2 || data !== 16'h8000) begin failures++; $display("FAIL basic_prefill got lvl=%0d data=%h exp 2 8000", level, data); end
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (data !== 16'h1234) begin failures++; $display("FAIL basic_first got=%h exp=1234", data); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0);
         checks++; if (data !== 16'h1234) begin failures++; $display("FAIL basic_hold got=%h exp=1234", data); end
      end
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (data !== 16'hABCD || level !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL basic_second got data=%h lvl=%0d e=%b exp abcd 0 1", data, level, empty); end
   endtask

   task automatic test_overflow();
      logic [15:0] vals [17];
      step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) vals[i] = 16'($urandom);
      for (int i = 0; i < 16; i++) step(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      checks++; if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got f=%b lvl=%0d o=%b exp 1 16 0", full, level, overflow); end
      step(1'b1, vals[16], 1'b0, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1 || level !== 5'd16) begin failures++; $display("FAIL ovf_flag got o=%b lvl=%0d exp 1 16", overflow, level); end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
         checks++; if (data !== vals[i]) begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, data, vals[i]); end
      end
      checks++; if (level !== 5'd0 || empty !== 1'b1 || underrun !== 1'b0) begin failures++; $display("FAIL ovf_drained got lvl=%0d e=%b u=%b exp 0 1 0", level, empty, underrun); end
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_underrun();
      step(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (data !== 16'h4000) begin failures++; $display("FAIL und_pre got=%h exp=4000", data); end
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (data !== 16'h8000 || underrun !== 1'b1) begin failures++; $display("FAIL und_event got data=%h u=%b exp 8000 1", data, underrun); end
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL und_clear got=%b exp=0", underrun); end
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL und_clr_race got=%b exp=1", underrun); end
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_simultaneous();
      logic [15:0] w;
      step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      w = mq[0];
      step(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
      checks++; if (level !== 5'd16 || overflow !== 1'b0 || data !== w) begin failures++; $display("FAIL sim_full got lvl=%0d o=%b data=%h exp 16 0 %h", level, overflow, data, w); end
      step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      w = 16'($urandom);
      step(1'b1, w, 1'b1, 1'b0, 1'b0);
      checks++; if (level !== 5'd1 || underrun !== 1'b1 || data !== 16'h8000) begin failures++; $display("FAIL sim_empty got lvl=%0d u=%b data=%h exp 1 1 8000", level, underrun, data); end
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (data !== w || level !== 5'd0) begin failures++; $display("FAIL sim_empty_rd got data=%h lvl=%0d exp %h 0", data, level, w); end
   endtask

   task automatic test_flush();
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (level !== 5'd8 || underrun !== 1'b1 || almost_empty !== 1'b0) begin failures++; $display("FAIL flush_pre got lvl=%0d u=%b ae=%b exp 8 1 0", level, underrun, almost_empty); end
      step(1'b1, 16'h7777, 1'b1, 1'b1, 1'b0);
      checks++; if (level !== 5'd0 || data !== 16'h8000 || underrun !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL flush got lvl=%0d data=%h u=%b o=%b e=%b exp 0 8000 0 0 1", level, data, underrun, overflow, empty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      wr_en = 1'b1; wr_data = 16'hDEAD; rd = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (level !== 5'd0 || data !== 16'h8000 || empty !== 1'b1) begin failures++; $display("FAIL async_reset got lvl=%0d data=%h e=%b exp 0 8000 1", level, data, empty); end
      wr_en = 1'b0; rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (data !== 16'h8000 || underrun !== 1'b1) begin failures++; $display("FAIL async_reset_empty got data=%h u=%b exp 8000 1", data, underrun); end
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(99, 0));
         step(($urandom_range(99, 0) < 55), 16'($urandom), ($urandom_range(99, 0) < 45),
              (r < 2), (r >= 2 && r < 7));
         checks++; if (data !== m_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, data, m_data); end
         checks++; if (level !== 5'(mq.size())) begin failures++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, mq.size()); end
         checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || almost_empty !== (mq.size() <= AE)) begin
            failures++; $display("FAIL rnd_status cyc=%0d got f=%b e=%b ae=%b lvl_exp=%0d", i, full, empty, almost_empty, mq.size());
         end
         checks++; if (overflow !== m_ovf || underrun !== m_und) begin failures++; $display("FAIL rnd_flags cyc=%0d got o=%b u=%b exp %b %b", i, overflow, underrun, m_ovf, m_und); end
`ifdef IIC_SAMPLE_FIFO_UNDERRUN_CNT_EN
         checks++; if (ucnt !== 8'(m_cnt)) begin failures++; $display("FAIL rnd_ucnt cyc=%0d got=%0d exp=%0d", i, ucnt, m_cnt); end
`endif
      end
   endtask

`ifdef IIC_SAMPLE_FIFO_UNDERRUN_CNT_EN
   task automatic test_underrun_cnt();
      step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      checks++; if (ucnt !== 8'd0) begin failures++; $display("FAIL cnt_flush got=%0d exp=0", ucnt); end
      for (int i = 0; i < 300; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (ucnt !== 8'd255) begin failures++; $display("FAIL cnt_sat got=%0d exp=255", ucnt); end
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      checks++; if (ucnt !== 8'd1) begin failures++; $display("FAIL cnt_clr_race got=%0d exp=1", ucnt); end
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      checks++; if (ucnt !== 8'd0) begin failures++; $display("FAIL cnt_clr got=%0d exp=0", ucnt); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; rd = 1'b0; flush = 1'b0; clr_flags = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_overflow();
      test_underrun();
      test_simultaneous();
      test_flush();
      test_async_reset();
      test_random();
`ifdef IIC_SAMPLE_FIFO_UNDERRUN_CNT_EN
      test_underrun_cnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_iic_sample_fifo
